// File: rtl/sound_request_scheduler.sv
// rtl/sound_request_scheduler.sv - fixed-priority sound request scheduler with Avalon-MM control
// Optional preemption of a playing tone by a higher-priority request: SOUND_SCHED_PREEMPT_EN
module sound_request_scheduler #(
  parameter int TICK_DIV     = 50000,
  parameter int GAP_TICKS    = 10,
  parameter int HALF_PERIOD0 = 56818,
  parameter int HALF_PERIOD1 = 47778,
  parameter int HALF_PERIOD2 = 37921,
  parameter int HALF_PERIOD3 = 28409
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tone_out,
  output logic        busy,
  output logic [3:0]  grant
);

  localparam int HP_MAX01 = (HALF_PERIOD0 > HALF_PERIOD1) ? HALF_PERIOD0 : HALF_PERIOD1;
  localparam int HP_MAX23 = (HALF_PERIOD2 > HALF_PERIOD3) ? HALF_PERIOD2 : HALF_PERIOD3;
  localparam int HP_MAX   = (HP_MAX01 > HP_MAX23) ? HP_MAX01 : HP_MAX23;
  localparam int HW       = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int PW       = $clog2(TICK_DIV);
  localparam int GW       = $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  id_q, id_d;
  logic [15:0] dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [HW-1:0] half_q, half_d;
  logic        tone_q, tone_d;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  mask_q;
  logic [15:0] duration_q;
  logic [3:0]  req_meta, req_sync, req_prev;

  logic        wr, abort_act, tick, half_hit;
  logic [3:0]  clr, eligible, grant_clr, req_edge;
  logic [1:0]  low_id;
  logic [HW-1:0] hp_sel;
  logic [15:0] dur_load;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:16];
  assign wr        = chipselect & ~write_n;
  assign abort_act = wr && (address == 2'd3) && writedata[4] && (state_q != S_IDLE);
  assign clr       = (wr && (address == 2'd3)) ? writedata[3:0] : 4'b0;
  assign eligible  = pending_q & mask_q;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign half_hit  = (half_q == hp_sel);
  assign dur_load  = (duration_q == 16'd0) ? 16'd1 : duration_q;
  assign req_edge  = req_sync & ~req_prev;

  always_comb begin
    case (id_q)
      2'd0:    hp_sel = HW'(HALF_PERIOD0 - 1);
      2'd1:    hp_sel = HW'(HALF_PERIOD1 - 1);
      2'd2:    hp_sel = HW'(HALF_PERIOD2 - 1);
      default: hp_sel = HW'(HALF_PERIOD3 - 1);
    endcase
  end

  // Lowest eligible index wins
  always_comb begin
    low_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) low_id = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    presc_d   = tick ? '0 : presc_q + PW'(1);
    half_d    = half_q;
    tone_d    = tone_q;
    grant_clr = 4'b0;
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (|eligible) begin
          state_d   = S_PLAY;
          id_d      = low_id;
          grant_clr = 4'b1 << low_id;
          dur_d     = dur_load;
          presc_d   = '0;
          half_d    = '0;
        end
      end
      S_PLAY: begin
        if (half_hit) begin
          half_d = '0;
          tone_d = ~tone_q;
        end else begin
          half_d = half_q + HW'(1);
        end
        if (tick) begin
          dur_d = dur_q - 16'd1;
          if (dur_q == 16'd1) begin
            state_d = S_GAP;
            tone_d  = 1'b0;
            gap_d   = GW'(GAP_TICKS);
            presc_d = '0;
          end
        end
`ifdef SOUND_SCHED_PREEMPT_EN
        if (!abort_act && (|eligible) && (low_id < id_q)) begin
          state_d   = S_PLAY;
          id_d      = low_id;
          grant_clr = 4'b1 << low_id;
          dur_d     = dur_load;
          presc_d   = '0;
          half_d    = '0;
          tone_d    = 1'b0;
        end
`else
`endif
      end
      S_GAP: begin
        tone_d = 1'b0;
        if (tick) begin
          gap_d = gap_q - GW'(1);
          if (gap_q == GW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_act) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
    end
    // A new edge beats a same-cycle clear or grant
    pending_d = (pending_q & ~clr & ~grant_clr) | req_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      id_q       <= 2'd0;
      dur_q      <= 16'd0;
      gap_q      <= '0;
      presc_q    <= '0;
      half_q     <= '0;
      tone_q     <= 1'b0;
      pending_q  <= 4'b0;
      mask_q     <= 4'hF;
      duration_q <= 16'd200;
      req_meta   <= 4'b0;
      req_sync   <= 4'b0;
      req_prev   <= 4'b0;
      readdata   <= 32'd0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      presc_q   <= presc_d;
      half_q    <= half_d;
      tone_q    <= tone_d;
      pending_q <= pending_d;
      req_meta  <= req;
      req_sync  <= req_meta;
      req_prev  <= req_sync;
      if (wr && (address == 2'd1)) mask_q <= writedata[3:0];
      if (wr && (address == 2'd2)) duration_q <= writedata[15:0];
      if (!chipselect) begin
        readdata <= 32'd0;
      end else begin
        case (address)
          2'd0:    readdata <= {20'd0, mask_q, pending_q, 1'b0,
                                (state_q != S_IDLE) ? id_q : 2'd0, state_q != S_IDLE};
          2'd1:    readdata <= {28'd0, mask_q};
          2'd2:    readdata <= {16'd0, duration_q};
          default: readdata <= 32'd0;
        endcase
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign grant    = (state_q == S_PLAY) ? (4'b1 << id_q) : 4'b0;
  assign tone_out = tone_q;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// tb/tb_sound_request_scheduler.sv - randomized and directed bench with a timeline reference model
module tb_sound_request_scheduler;
  localparam int TD = 4;
  localparam int GT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tone_out;
  logic        busy;
  logic [3:0]  grant;

  int total = 0;
  int bad = 0;

  sound_request_scheduler #(
    .TICK_DIV(TD), .GAP_TICKS(GT),
    .HALF_PERIOD0(3), .HALF_PERIOD1(5), .HALF_PERIOD2(4), .HALF_PERIOD3(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .tone_out(tone_out), .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic int hp(input int id);
    case (id)
      0: return 3;
      1: return 5;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: playback is a timeline of entry/end cycles, tone is derived arithmetically
  int          cyc, m_mode, m_id, m_start, m_end, m_gend, low;
  logic [3:0]  m_pend, m_mask, h1, h2, h3, take, clr_m, elig;
  logic [15:0] m_dur;
  logic [31:0] m_rd;
  bit          m_wr, m_abort, m_pre;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; m_mode = 0; m_id = 0; m_start = 0; m_end = 0; m_gend = 0;
      m_pend = 0; m_mask = 4'hF; m_dur = 16'd200; m_rd = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      cyc++;
      m_wr    = chipselect && !write_n;
      m_abort = m_wr && address == 2'd3 && writedata[4] && m_mode != 0;
      clr_m   = (m_wr && address == 2'd3) ? writedata[3:0] : 4'b0;
      elig    = m_pend & m_mask;
      low     = lowest(elig);
      take    = 4'b0;
      if (!chipselect) m_rd = 0;
      else if (address == 2'd0)
        m_rd = {20'd0, m_mask, m_pend, 1'b0, (m_mode != 0) ? 2'(m_id) : 2'd0, m_mode != 0};
      else if (address == 2'd1) m_rd = {28'd0, m_mask};
      else if (address == 2'd2) m_rd = {16'd0, m_dur};
      else m_rd = 0;
      m_pre = 0;
`ifdef SOUND_SCHED_PREEMPT_EN
      m_pre = (m_mode == 1) && (low >= 0) && (low < m_id);
`endif
      if (m_abort) m_mode = 0;
      else if (m_pre || (m_mode == 0 && low >= 0)) begin
        m_mode = 1; m_id = low; take[low] = 1'b1; m_start = cyc;
        m_end = cyc + ((m_dur == 0) ? 1 : int'(m_dur)) * TD;
      end else if (m_mode == 1 && cyc == m_end) begin
        m_mode = 2; m_gend = cyc + GT * TD;
      end else if (m_mode == 2 && cyc == m_gend) m_mode = 0;
      m_pend = (m_pend & ~clr_m & ~take) | (h2 & ~h3);
      h3 = h2; h2 = h1; h1 = req;
      if (m_wr && address == 2'd1) m_mask = writedata[3:0];
      if (m_wr && address == 2'd2) m_dur = writedata[15:0];
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
    chk("grant", {28'd0, grant}, (m_mode == 1) ? (32'd1 << m_id) : 32'd0);
    chk("tone", {31'd0, tone_out},
        (m_mode == 1) ? 32'(((cyc - m_start) / hp(m_id)) % 2) : 32'd0);
    chk("readdata", readdata, m_rd);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1; write_n = 1; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 0;
  endtask

  task automatic pulse(input logic [3:0] b);
    @(negedge clk);
    req = req | b;
    repeat (2) @(negedge clk);
    req = req & ~b;
  endtask

  task automatic wait_grant(input logic [3:0] g, input int bound, input string nm);
    int n = 0;
    while (grant !== g && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {28'd0, grant}, {28'd0, g});
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] d;
  int n, rises, gaps, r;
  logic prev;

  initial begin
    reset_n = 0; req = 0; address = 0; chipselect = 0; write_n = 1; writedata = 0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_tone", {31'd0, tone_out}, 32'd0);
    reset_n = 1;

    // Single request: 5 ticks of 4 cycles, then 2 gap ticks
    bus_write(2'd2, 32'd5);
    pulse(4'b0001);
    wait_grant(4'b0001, 20, "t1_grant");
    n = 0; rises = 0; prev = 0;
    while (grant == 4'b0001 && n < 100) begin
      n++;
      if (tone_out && !prev) rises++;
      prev = tone_out;
      @(negedge clk);
    end
    chk("t1_play_cycles", n, 32'd20);
    chk("t1_tone_rises", rises, 32'd3);
    gaps = 0;
    while (busy && grant == 4'b0 && gaps < 100) begin
      gaps++;
      @(negedge clk);
    end
    chk("t1_gap_cycles", gaps, 32'd8);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Simultaneous requests 1 and 3
    pulse(4'b1010);
    wait_grant(4'b0010, 20, "t2_first");
    bus_read(2'd0, d);
    chk("t2_pending", {28'd0, d[7:4]}, 32'h8);
    chk("t2_id_busy", {29'd0, d[2:0]}, 32'h3);
    wait_grant(4'b1000, 60, "t2_second");
    wait_idle(60);

    // Masked request stays pending until cleared
    bus_write(2'd1, 32'hE);
    pulse(4'b0001);
    repeat (8) @(negedge clk);
    chk("t3_no_play", {31'd0, busy}, 32'd0);
    bus_read(2'd0, d);
    chk("t3_pending", {28'd0, d[7:4]}, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd0, d);
    chk("t3_cleared", {28'd0, d[7:4]}, 32'h0);
    bus_write(2'd1, 32'hF);

    // Abort during playback
    pulse(4'b0100);
    wait_grant(4'b0100, 20, "t4_grant");
    repeat (3) @(negedge clk);
    bus_write(2'd3, 32'h10);
    chk("t4_abort_busy", {31'd0, busy}, 32'd0);
    chk("t4_abort_grant", {28'd0, grant}, 32'd0);
    chk("t4_abort_tone", {31'd0, tone_out}, 32'd0);

    // Higher-priority request during playback
    pulse(4'b0100);
    wait_grant(4'b0100, 20, "t5_grant2");
    pulse(4'b0001);
    repeat (3) @(negedge clk);
`ifdef SOUND_SCHED_PREEMPT_EN
    chk("t5_preempt", {28'd0, grant}, 32'h1);
`else
    chk("t5_no_preempt", {28'd0, grant}, 32'h4);
    wait_grant(4'b0001, 60, "t5_after_gap");
`endif
    wait_idle(100);
    bus_read(2'd0, d);
    chk("t5_pending", {28'd0, d[7:4]}, 32'h0);

    // Asynchronous reset mid-playback
    pulse(4'b0010);
    wait_grant(4'b0010, 20, "t6_grant");
    @(negedge clk);
    chipselect = 1; address = 2'd0;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("t6_rd", readdata, 32'd0);
    chk("t6_tone", {31'd0, tone_out}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chipselect = 0;
    @(negedge clk);
    reset_n = 1;
    bus_read(2'd1, d);
    chk("t6_mask", d, 32'hF);
    bus_write(2'd2, 32'd3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chipselect = 0; write_n = 1;
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      r = $urandom_range(0, 99);
      address = 2'($urandom);
      writedata = $urandom;
      if (r < 15) begin
        chipselect = 1;
      end else if (r < 18) begin
        chipselect = 1; write_n = 0; address = 2'd1;
        writedata = {28'd0, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF};
      end else if (r < 20) begin
        chipselect = 1; write_n = 0; address = 2'd2;
        writedata = 32'($urandom_range(0, 4));
      end else if (r < 22) begin
        chipselect = 1; write_n = 0; address = 2'd3;
        writedata = {27'd0, $urandom_range(0, 4) == 0, 4'($urandom)};
      end else if (r < 23) begin
        chipselect = 1; write_n = 0; address = 2'd0;
      end
    end
    @(negedge clk);
    chipselect = 0; write_n = 1; req = 0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sound_request_scheduler.md
# sound_request_scheduler

Arbitrates four one-bit sound-trigger inputs (start, hit, score, fail) onto a single square-wave tone output for the board speaker pin. Latches request edges, grants them by fixed priority, and plays each for a CPU-programmed duration followed by a silent gap. Sits beside the PIO input ports as an Avalon-MM slave on the system interconnect, so software can mask, clear, abort and read status.

## Interface
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); ≥2
- GAP_TICKS, 10, silent ticks after each tone; ≥1
- HALF_PERIOD0..HALF_PERIOD3, 56818/47778/37921/28409, clk cycles per tone half-period for requester 0..3; ≥1
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  4  asynchronous trigger inputs; rising edge requests playback
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- tone_out  out  1  square-wave speaker drive
- busy  out  1  high when state ≠ IDLE
- grant  out  4  one-hot active requester, high only in PLAY

## Operation
- req[i] passes a two-flop synchronizer plus edge register; a synchronized rising edge sets pending[i]. Set wins over a same-cycle clear.
- Registers (addresses):
  - 0 R: bit0 busy, bits[2:1] active id, bits[7:4] pending, bits[11:8] mask; others 0.
  - 1 R/W: mask[3:0], reset 4'hF.
  - 2 R/W: duration[15:0] in ticks, reset 16'd200; a value of 0 plays as 1.
  - 3 W: bits[3:0] write-1-to-clear pending; bit4 = abort. Reads 0.
- FSM IDLE / PLAY / GAP:
  - IDLE: if pending & mask ≠ 0, grant the lowest index, clear its pending bit, load the duration counter, zero the prescaler and half-period counter, and enter PLAY.
  - PLAY: tone_out toggles each HALF_PERIOD[id] cycles and starts at 0. The duration counter decrements on each tick. At 0, force tone_out = 0, load GAP_TICKS, and enter GAP.
  - GAP: count ticks, then go to IDLE.
  - Abort in PLAY or GAP: next cycle IDLE, tone_out = 0, grant = 0. Pending bits untouched.
- A new edge on the active requester during PLAY re-pends it; it replays after the gap.
- Clearing the active id's mask bit does not stop the current playback.
- Reset mid-playback: all outputs and state return to reset values immediately.

## Timing
- Reset values: readdata 0, tone_out 0, busy 0, grant 0, pending 0, state IDLE.
- req high (setup met) → pending set at the 3rd rising clk edge.
- Pending visible → PLAY entered at the next edge. From IDLE, grant/busy assert 1 cycle after pending sets.
- Prescaler restarts at PLAY/GAP entry. PLAY lasts exactly duration×TICK_DIV cycles, and GAP lasts exactly GAP_TICKS×TICK_DIV cycles.
- First tone_out rise is HALF_PERIOD[id] cycles after PLAY entry.
- Writes take effect at the edge where chipselect & !write_n. readdata updates on the next edge after address/chipselect, one-cycle latency, with no wait states. With chipselect low, readdata loads 0.

## Configuration
- SOUND_SCHED_PREEMPT_EN defined: in PLAY, a pending & mask bit with index < active id switches to that requester on the next edge.
  - The switch reloads duration, prescaler and half-period, and clears the new requester's pending bit.
  - The preempted request is dropped, not re-pended.
  - GAP is never preempted.
- Undefined: non-preemptive. Playback always runs to completion or abort.

## Test plan
- TICK_DIV=4, GAP_TICKS=2, HALF_PERIOD0=3, duration=5; pulse req[0] → grant=0001 for 20 cycles, tone_out toggles every 3 cycles, then 8 silent cycles with busy=1, then busy=0.
- req[3] and req[1] rise in the same cycle → req[1] plays first, then req[3] after the gap. Status reads pending=4'b1000 during the first tone.
- Write mask=4'b1110, pulse req[0] → no playback, status pending bit0=1. Write address 3 data 0x1 → pending=0.
- During PLAY, write address 3 data 0x10 → next cycle busy=0, grant=0, tone_out=0.
- With SOUND_SCHED_PREEMPT_EN, req[2] playing and req[0] pulsed → grant switches to 0001 and plays a full duration, with req[2] not re-pended. Without the macro → req[0] plays after req[2] completes plus the gap.
- Assert reset_n=0 mid-PLAY → readdata, tone_out, busy and grant go to 0 asynchronously, and mask reads 4'hF after release.
